io_ctrl: RTL and testbench

IO_CTRL -- requirements
Module: io_ctrl

---
 rtl/io_ctrl_if.sv | 27 ++
 rtl/io_ctrl.sv | 98 +++++++++
 tb/tb_io_ctrl.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/io_ctrl_if.sv
// CPU bus, RAM write strobe, RX/TX byte streams and stop flag of io_ctrl.
interface io_ctrl_if;
  logic [31:0] cpu_a;
  logic        cpu_wr;
  logic [7:0]  cpu_dout;
  logic [7:0]  cpu_din;
  logic        rdy_out;
  logic [7:0]  ram_din;
  logic        ram_we;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        prog_stop;

  modport master (
    output cpu_a, cpu_wr, cpu_dout, ram_din, rx_valid, rx_data, tx_ready,
    input  cpu_din, rdy_out, ram_we, rx_ready, tx_valid, tx_data, prog_stop
  );

  modport slave (
    input  cpu_a, cpu_wr, cpu_dout, ram_din, rx_valid, rx_data, tx_ready,
    output cpu_din, rdy_out, ram_we, rx_ready, tx_valid, tx_data, prog_stop
  );
endinterface

// File: rtl/io_ctrl.sv
// Memory-mapped IO controller: RAM/IO decode, RX/TX byte FIFOs, cycle counter, stop flag; read data one cycle after address.
// rdy_out drops while an RX pop finds the RX FIFO empty or a TX push finds the TX FIFO full.
module io_ctrl #(
  parameter int unsigned RX_DEPTH  = 16,
  parameter int unsigned TX_DEPTH  = 16,
  parameter logic [31:0] CNT_RESET = 32'h0
) (
  input logic      clk_in,
  input logic      rst_in,
  io_ctrl_if.slave bus
);
  localparam int unsigned RX_AW = $clog2(RX_DEPTH);
  localparam int unsigned TX_AW = $clog2(TX_DEPTH);
  localparam logic [RX_AW:0] RX_ONE = 1;
  localparam logic [TX_AW:0] TX_ONE = 1;

  logic [7:0]     rx_mem [RX_DEPTH];
  logic [7:0]     tx_mem [TX_DEPTH];
  logic [RX_AW:0] rx_wp, rx_rp;
  logic [TX_AW:0] tx_wp, tx_rp;
  logic           rx_full, rx_empty, tx_full, tx_empty;
  logic [31:0]    cnt, snap;
  logic           io_flag, stop;
  logic [7:0]     io_rdat, rd_byte;
  logic [17:0]    addr;
  logic           io_acc, rd_rx, wr_tx, rdy;
  logic           rx_push, rx_pop, tx_push, tx_pop;
  logic           unused_a_hi;

  assign addr        = bus.cpu_a[17:0];
  assign unused_a_hi = ^bus.cpu_a[31:18];
  assign io_acc      = (addr[17:16] == 2'b11);

  // Extra pointer MSB tells a full FIFO apart from an empty one.
  assign rx_empty = (rx_wp == rx_rp);
  assign rx_full  = (rx_wp[RX_AW] != rx_rp[RX_AW]) && (rx_wp[RX_AW-1:0] == rx_rp[RX_AW-1:0]);
  assign tx_empty = (tx_wp == tx_rp);
  assign tx_full  = (tx_wp[TX_AW] != tx_rp[TX_AW]) && (tx_wp[TX_AW-1:0] == tx_rp[TX_AW-1:0]);

  assign rd_rx = io_acc && !bus.cpu_wr && (addr == 18'h30000);
  assign wr_tx = io_acc && bus.cpu_wr && (addr == 18'h30000) && (bus.cpu_dout != 8'h00);
  assign rdy   = !((rd_rx && rx_empty) || (wr_tx && tx_full));

  assign rx_push = bus.rx_valid && !rx_full;
  assign rx_pop  = rd_rx && rdy;
  assign tx_push = wr_tx && rdy;
  assign tx_pop  = !tx_empty && bus.tx_ready;

  assign bus.rdy_out   = rdy;
  assign bus.ram_we    = bus.cpu_wr && !io_acc && rdy;
  assign bus.rx_ready  = !rx_full;
  assign bus.tx_valid  = !tx_empty;
  assign bus.tx_data   = tx_mem[tx_rp[TX_AW-1:0]];
  assign bus.prog_stop = stop;
  assign bus.cpu_din   = io_flag ? io_rdat : bus.ram_din;

  always_comb begin
    rd_byte = 8'h00;
    case (addr)
      18'h30000: rd_byte = rx_mem[rx_rp[RX_AW-1:0]];
      18'h30004: rd_byte = cnt[7:0];
      18'h30005: rd_byte = snap[15:8];
      18'h30006: rd_byte = snap[23:16];
      18'h30007: rd_byte = snap[31:24];
      default:   rd_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rx_wp   <= '0;
      rx_rp   <= '0;
      tx_wp   <= '0;
      tx_rp   <= '0;
      cnt     <= CNT_RESET;
      snap    <= 32'h0;
      io_flag <= 1'b0;
      io_rdat <= 8'h00;
      stop    <= 1'b0;
    end else begin
      cnt     <= cnt + 32'd1;
      io_flag <= io_acc;
      io_rdat <= rd_byte;
      if (rx_push) rx_wp <= rx_wp + RX_ONE;
      if (rx_pop)  rx_rp <= rx_rp + RX_ONE;
      if (tx_push) tx_wp <= tx_wp + TX_ONE;
      if (tx_pop)  tx_rp <= tx_rp + TX_ONE;
      if (io_acc && !bus.cpu_wr && rdy && (addr == 18'h30004)) snap <= cnt;
      if (io_acc && bus.cpu_wr && (addr == 18'h30004)) stop <= 1'b1;
    end
  end

  // Storage needs no reset: the pointers alone decide what is valid.
  always_ff @(posedge clk_in) begin
    if (rx_push) rx_mem[rx_wp[RX_AW-1:0]] <= bus.rx_data;
    if (tx_push) tx_mem[tx_wp[TX_AW-1:0]] <= bus.cpu_dout;
  end
endmodule

// File: tb/tb_io_ctrl.sv
// Bench for io_ctrl: directed scenarios with literal expectations, then a long randomized run
// compared every cycle against a queue-based model of the CPU-visible behaviour.
module tb_io_ctrl;
  localparam int RXD = 16;
  localparam int TXD = 16;
  localparam logic [31:0] PRELOAD = 32'hFFFF_FFF8;

  logic clk_in = 1'b0;
  logic rst_in;
  io_ctrl_if bus ();
  io_ctrl_if bus2 ();

  io_ctrl #(.RX_DEPTH(RXD), .TX_DEPTH(TXD)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .bus(bus)
  );
  io_ctrl #(.RX_DEPTH(RXD), .TX_DEPTH(TXD), .CNT_RESET(PRELOAD)) dut_wrap (
    .clk_in(clk_in), .rst_in(rst_in), .bus(bus2)
  );

  always #5 clk_in = ~clk_in;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
  endtask

  function automatic logic [7:0] ram_pat(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // ---------------- behavioural model + per-cycle compare ----------------
  logic [7:0]  rxq[$];
  logic [7:0]  txq[$];
  logic [31:0] m_cnt, m_snap;
  logic        m_stop, m_valid, din_chk;
  logic [7:0]  din_exp;

  initial begin
    logic [17:0] a18;
    logic io, wr, rd_rx, wr_tx, rdy, rx_acc, tx_out;
    m_valid = 1'b0;
    din_chk = 1'b0;
    forever begin
      @(negedge clk_in);
      #2;
      if (m_valid) begin
        a18   = bus.cpu_a[17:0];
        io    = (a18[17:16] == 2'b11);
        wr    = bus.cpu_wr;
        rd_rx = io && !wr && (a18 == 18'h30000);
        wr_tx = io && wr && (a18 == 18'h30000) && (bus.cpu_dout != 8'h00);
        rdy   = !((rd_rx && rxq.size() == 0) || (wr_tx && txq.size() == TXD));
        chk("rdy_out", bus.rdy_out, rdy);
        chk("ram_we", bus.ram_we, wr && !io && rdy);
        chk("rx_ready", bus.rx_ready, rxq.size() < RXD);
        chk("tx_valid", bus.tx_valid, txq.size() > 0);
        if (txq.size() > 0) chk("tx_data", bus.tx_data, txq[0]);
        chk("prog_stop", bus.prog_stop, m_stop);
        if (din_chk) chk("cpu_din", bus.cpu_din, din_exp);
      end
      if (rst_in) begin
        rxq.delete();
        txq.delete();
        m_cnt   = 32'h0;
        m_snap  = 32'h0;
        m_stop  = 1'b0;
        din_exp = 8'h00;
        din_chk = 1'b1;
        m_valid = 1'b1;
      end else if (m_valid) begin
        rx_acc  = bus.rx_valid && (rxq.size() < RXD);
        tx_out  = bus.tx_ready && (txq.size() > 0);
        din_chk = 1'b0;
        if (rdy && !wr) begin
          din_chk = 1'b1;
          if (!io) din_exp = ram_pat(bus.cpu_a);
          else begin
            case (a18)
              18'h30000: din_exp = rxq.pop_front();
              18'h30004: begin din_exp = m_cnt[7:0]; m_snap = m_cnt; end
              18'h30005: din_exp = m_snap[15:8];
              18'h30006: din_exp = m_snap[23:16];
              18'h30007: din_exp = m_snap[31:24];
              default:   din_exp = 8'h00;
            endcase
          end
        end
        if (rdy && wr && io && (a18 == 18'h30004)) m_stop = 1'b1;
        if (tx_out) void'(txq.pop_front());
        if (rdy && wr_tx) txq.push_back(bus.cpu_dout);
        if (rx_acc) rxq.push_back(bus.rx_data);
        m_cnt = m_cnt + 32'd1;
      end
    end
  end

  // ---------------- driver ----------------
  logic [31:0] last_a;
  logic        last_rst;
  logic [31:0] a2;
  logic        rec_on;
  logic [7:0]  drained[$];

  task automatic step(input logic rst, input logic [31:0] a, input logic wr, input logic [7:0] d,
                      input logic rxv, input logic [7:0] rxd, input logic txr);
    @(negedge clk_in);
    bus.ram_din  = last_rst ? 8'h00 : ram_pat(last_a);
    rst_in       = rst;
    bus.cpu_a    = a;
    bus.cpu_wr   = wr;
    bus.cpu_dout = d;
    bus.rx_valid = rxv;
    bus.rx_data  = rxd;
    bus.tx_ready = txr;
    bus2.cpu_a   = a2;
    last_a       = a;
    last_rst     = rst;
    #3;
    if (rec_on && txr && bus.tx_valid === 1'b1) drained.push_back(bus.tx_data);
  endtask

  task automatic idle(input int n, input logic txr);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 8'h00, 1'b0, 8'h00, txr);
  endtask

  initial begin
    logic [31:0] w, a;
    logic        wr, rxv, txr, rst;
    logic [7:0]  d;
    int          rx_p, tx_p, sel;

    rst_in = 1'b1;
    bus.cpu_a = 32'h0;  bus.cpu_wr = 1'b0;  bus.cpu_dout = 8'h00; bus.ram_din = 8'h00;
    bus.rx_valid = 1'b0; bus.rx_data = 8'h00; bus.tx_ready = 1'b0;
    bus2.cpu_a = 32'h0; bus2.cpu_wr = 1'b0; bus2.cpu_dout = 8'h00; bus2.ram_din = 8'h00;
    bus2.rx_valid = 1'b0; bus2.rx_data = 8'h00; bus2.tx_ready = 1'b0;
    a2 = 32'h0; last_a = 32'h0; last_rst = 1'b1; rec_on = 1'b0;

    step(1'b1, 32'h0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    step(1'b1, 32'h0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

    // Reset state, then counter snapshot 100 cycles after reset.
    idle(1, 1'b0);
    chk("rst_rdy_out", bus.rdy_out, 1'b1);
    chk("rst_rx_ready", bus.rx_ready, 1'b1);
    chk("rst_tx_valid", bus.tx_valid, 1'b0);
    chk("rst_prog_stop", bus.prog_stop, 1'b0);
    chk("rst_cpu_din", bus.cpu_din, 8'h00);
    idle(99, 1'b0);
    step(1'b0, 32'h30004, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    step(1'b0, 32'h30005, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    w[7:0] = bus.cpu_din;
    chk("cnt_byte0", bus.cpu_din, 8'h64);
    step(1'b0, 32'h30006, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    w[15:8] = bus.cpu_din;
    step(1'b0, 32'h30007, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    w[23:16] = bus.cpu_din;
    idle(1, 1'b0);
    w[31:24] = bus.cpu_din;
    chk("cnt_snapshot", w, 32'd100);

    // Two RX bytes read back in order.
    step(1'b0, 32'h0, 1'b0, 8'h00, 1'b1, 8'h41, 1'b0);
    step(1'b0, 32'h0, 1'b0, 8'h00, 1'b1, 8'h42, 1'b0);
    step(1'b0, 32'h30000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    step(1'b0, 32'h30000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    chk("rx_first", bus.cpu_din, 8'h41);
    idle(1, 1'b0);
    chk("rx_second", bus.cpu_din, 8'h42);

    // Read from empty RX stalls until a byte arrives.
    step(1'b0, 32'h30000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    chk("rx_empty_stall", bus.rdy_out, 1'b0);
    step(1'b0, 32'h30000, 1'b0, 8'h00, 1'b1, 8'h55, 1'b0);
    chk("rx_empty_stall_push", bus.rdy_out, 1'b0);
    step(1'b0, 32'h30000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    chk("rx_stall_release", bus.rdy_out, 1'b1);
    idle(1, 1'b0);
    chk("rx_stall_data", bus.cpu_din, 8'h55);

    // Fill TX, stall on the 17th, drain in order; zero write never emitted.
    for (int i = 1; i <= 16; i++) step(1'b0, 32'h30000, 1'b1, 8'(i), 1'b0, 8'h00, 1'b0);
    step(1'b0, 32'h30000, 1'b1, 8'h11, 1'b0, 8'h00, 1'b0);
    chk("tx_full_stall", bus.rdy_out, 1'b0);
    step(1'b0, 32'h30000, 1'b1, 8'h11, 1'b0, 8'h00, 1'b0);
    chk("tx_full_hold", bus.rdy_out, 1'b0);
    rec_on = 1'b1;
    step(1'b0, 32'h30000, 1'b1, 8'h11, 1'b0, 8'h00, 1'b1);
    chk("tx_full_pop_cycle", bus.rdy_out, 1'b0);
    step(1'b0, 32'h30000, 1'b1, 8'h11, 1'b0, 8'h00, 1'b1);
    chk("tx_stall_release", bus.rdy_out, 1'b1);
    step(1'b0, 32'h30000, 1'b1, 8'h00, 1'b0, 8'h00, 1'b1);
    chk("tx_zero_no_stall", bus.rdy_out, 1'b1);
    idle(20, 1'b1);
    rec_on = 1'b0;
    chk("tx_drain_count", drained.size(), 17);
    for (int i = 0; i < drained.size(); i++) chk("tx_drain_order", drained[i], i + 1);

    // Sticky stop flag and a single-cycle RAM write.
    step(1'b0, 32'h30004, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
    chk("stop_before_edge", bus.prog_stop, 1'b0);
    idle(1, 1'b0);
    chk("stop_set", bus.prog_stop, 1'b1);
    step(1'b0, 32'h01000, 1'b1, 8'hAB, 1'b0, 8'h00, 1'b0);
    chk("ram_we_on", bus.ram_we, 1'b1);
    idle(1, 1'b0);
    chk("ram_we_off", bus.ram_we, 1'b0);
    idle(5, 1'b0);
    chk("stop_sticky", bus.prog_stop, 1'b1);

    // Randomized traffic with phase-varying FIFO pressure and rare resets.
    rx_p = 50;
    tx_p = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) begin
        rx_p = $urandom_range(5, 95);
        tx_p = $urandom_range(5, 95);
      end
      a   = $urandom;
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2, 3: a[17:0] = 18'h30000;
        4: a[17:0] = 18'h30004;
        5: a[17:0] = 18'h30005;
        6: a[17:0] = 18'h30006;
        7: a[17:0] = 18'h30007;
        8: a[17:16] = 2'b11;
        default: a[17:16] = 2'($urandom_range(0, 2));
      endcase
      wr  = ($urandom_range(0, 99) < 45);
      d   = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      rxv = ($urandom_range(0, 99) < rx_p);
      txr = ($urandom_range(0, 99) < tx_p);
      rst = ($urandom_range(0, 299) == 0);
      step(rst, a, wr, d, rxv, 8'($urandom), txr);
    end

    // Reset with both FIFOs half full and stop set.
    step(1'b1, 32'h0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 32'h30000, 1'b1, 8'(8'h80 + i), 1'b1, 8'(8'h20 + i), 1'b0);
    step(1'b0, 32'h30004, 1'b1, 8'h77, 1'b0, 8'h00, 1'b0);
    idle(1, 1'b0);
    chk("pre_rst_tx_valid", bus.tx_valid, 1'b1);
    step(1'b1, 32'h0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

    // Post-reset checks on the main instance, counter wrap on the preloaded one.
    for (int k = 0; k < 12; k++) begin
      case (k)
        6, 8:    a2 = 32'h30004;
        7, 10:   a2 = 32'h30007;
        9:       a2 = 32'h30005;
        default: a2 = 32'h0;
      endcase
      idle(1, 1'b0);
      case (k)
        0: begin
          chk("mid_rst_tx_valid", bus.tx_valid, 1'b0);
          chk("mid_rst_rx_ready", bus.rx_ready, 1'b1);
          chk("mid_rst_prog_stop", bus.prog_stop, 1'b0);
          chk("mid_rst_cpu_din", bus.cpu_din, 8'h00);
          chk("mid_rst_rdy_out", bus.rdy_out, 1'b1);
        end
        7:  chk("wrap_cnt_fe", bus2.cpu_din, 8'hFE);
        8:  chk("wrap_snap_top_ff", bus2.cpu_din, 8'hFF);
        9:  chk("wrap_cnt_zero", bus2.cpu_din, 8'h00);
        10: chk("wrap_snap_b1", bus2.cpu_din, 8'h00);
        11: chk("wrap_snap_top_zero", bus2.cpu_din, 8'h00);
        default: ;
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
